// File: rtl/sgd_wb_pkg.sv
// Shared types and helpers for the write-back scheduler.
package sgd_wb_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    CMD  = 4'b0010,
    DATA = 4'b0100,
    DONE = 4'b1000
  } state_t;

  localparam int BYTES_PER_BEAT = 64;

  function automatic logic [31:0] burst_len(input logic [31:0] remaining,
                                            input logic [31:0] max_beats);
    return (remaining < max_beats) ? remaining : max_beats;
  endfunction

endpackage

// File: rtl/sgd_wb_cmd_gen.sv
// Write-command generator: computes burst address/length and registers the
// cmd_* strobe and fields for the cycle after the CMD state.
module sgd_wb_cmd_gen
  import sgd_wb_pkg::*;
#(
  parameter int BURST_BEATS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fire,
  input  logic [63:0] base,
  input  logic [31:0] issued,
  input  logic [31:0] remaining,
  output logic [31:0] burst,
  output logic        cmd_start,
  output logic [63:0] cmd_addr,
  output logic [31:0] cmd_length
);

  assign burst = burst_len(remaining, 32'(BURST_BEATS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_start  <= 1'b0;
      cmd_addr   <= '0;
      cmd_length <= '0;
    end else begin
      cmd_start <= fire;
      if (fire) begin
        cmd_addr   <= base + 64'(issued) * 64'(BYTES_PER_BEAT);
        cmd_length <= burst * 32'(BYTES_PER_BEAT);
      end
    end
  end

endmodule

// File: rtl/sgd_x_wb_scheduler.sv
// Round-robin write-back scheduler draining per-engine FIFOs into host bursts.
// Optional macro SGD_WB_STALL_CNT_EN enables the stall_cycles counter.
module sgd_x_wb_scheduler
  import sgd_wb_pkg::*;
#(
  parameter int ENGINE_NUM  = 8,
  parameter int DATA_WIDTH  = 512,
  parameter int BURST_BEATS = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [63:0]                      addr_base,
  input  logic [31:0]                      total_beats,
  input  logic [ENGINE_NUM*DATA_WIDTH-1:0] src_data,
  input  logic [ENGINE_NUM-1:0]            src_empty,
  output logic [ENGINE_NUM-1:0]            src_rd_en,
  output logic                             cmd_start,
  output logic [63:0]                      cmd_addr,
  output logic [31:0]                      cmd_length,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_almost_full,
  output logic                             busy,
  output logic                             done,
  output logic [31:0]                      beat_cnt,
  output logic [31:0]                      stall_cycles
);

  localparam int RR_W = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;

  state_t          state;
  logic [RR_W-1:0] rr;
  logic [63:0]     base;
  logic [31:0]     remaining;
  logic [31:0]     burst_left;
  logic [31:0]     burst;
  logic            pop;
  logic            fire;

  // A stalled head blocks the pass: rr is never advanced past an empty FIFO.
  assign pop  = (state == DATA) && !src_empty[rr] && !out_almost_full;
  assign fire = (state == CMD);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    src_rd_en     = '0;
    src_rd_en[rr] = pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr         <= '0;
      base       <= '0;
      remaining  <= '0;
      burst_left <= '0;
      beat_cnt   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base      <= addr_base;
            remaining <= total_beats;
            beat_cnt  <= '0;
            rr        <= '0;
            state     <= (total_beats == 32'd0) ? DONE : CMD;
          end
        end
        CMD: begin
          burst_left <= burst;
          state      <= DATA;
        end
        DATA: begin
          if (pop) begin
            out_data   <= src_data[int'(rr)*DATA_WIDTH +: DATA_WIDTH];
            out_valid  <= 1'b1;
            rr         <= (rr == RR_W'(ENGINE_NUM - 1)) ? '0 : rr + 1'b1;
            burst_left <= burst_left - 32'd1;
            remaining  <= remaining - 32'd1;
            beat_cnt   <= beat_cnt + 32'd1;
            if (burst_left == 32'd1)
              state <= (remaining > 32'd1) ? CMD : DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // beat_cnt doubles as the issued-beat count used for burst addressing.
  sgd_wb_cmd_gen #(.BURST_BEATS(BURST_BEATS)) u_cmd_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .fire       (fire),
    .base       (base),
    .issued     (beat_cnt),
    .remaining  (remaining),
    .burst      (burst),
    .cmd_start  (cmd_start),
    .cmd_addr   (cmd_addr),
    .cmd_length (cmd_length)
  );

`ifdef SGD_WB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (state == IDLE && start)
      stall_cycles <= '0;
    else if (state == DATA && !pop && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sgd_x_wb_scheduler.sv
// Scoreboard bench for sgd_x_wb_scheduler: FWFT FIFO model, command and beat queues.
module tb_sgd_x_wb_scheduler;

  localparam int EN = 8;
  localparam int DW = 512;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [63:0]   addr_base;
  logic [31:0]   total_beats;
  logic [EN*DW-1:0] src_data;
  logic [EN-1:0] src_empty;
  logic [EN-1:0] src_rd_en;
  logic          cmd_start;
  logic [63:0]   cmd_addr;
  logic [31:0]   cmd_length;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_almost_full;
  logic          busy;
  logic          done;
  logic [31:0]   beat_cnt;
  logic [31:0]   stall_cycles;

  sgd_x_wb_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .addr_base       (addr_base),
    .total_beats     (total_beats),
    .src_data        (src_data),
    .src_empty       (src_empty),
    .src_rd_en       (src_rd_en),
    .cmd_start       (cmd_start),
    .cmd_addr        (cmd_addr),
    .cmd_length      (cmd_length),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_almost_full (out_almost_full),
    .busy            (busy),
    .done            (done),
    .beat_cnt        (beat_cnt),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned fifo_cnt[EN];
  int unsigned pred_cnt[EN];
  logic [EN-1:0] empty_force;

  logic [DW-1:0] data_q[$];
  logic [95:0]   cmd_q[$];
  int cmd_seen, beats_seen, done_seen;

  function automatic logic [DW-1:0] mkData(input int eng, input int unsigned cnt);
    logic [7:0]  e8;
    logic [23:0] c24;
    e8  = 8'(eng);
    c24 = 24'(cnt);
    return {16{e8, c24}};
  endfunction

  initial for (int i = 0; i < EN; i++) fifo_cnt[i] = 0;

  always_comb begin
    for (int i = 0; i < EN; i++) src_data[i*DW +: DW] = mkData(i, fifo_cnt[i]);
    src_empty = empty_force;
  end

  always @(posedge clk)
    for (int j = 0; j < EN; j++)
      if (src_rd_en[j]) fifo_cnt[j] <= fifo_cnt[j] + 1;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Monitor: every beat and command the DUT produces is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        beats_seen++;
        checkOutput("beat_expected", DW'(data_q.size() > 0), DW'(1));
        if (data_q.size() > 0) checkOutput("beat_data", out_data, data_q.pop_front());
      end
      if (cmd_start) begin
        cmd_seen++;
        checkOutput("cmd_expected", DW'(cmd_q.size() > 0), DW'(1));
        if (cmd_q.size() > 0) checkOutput("cmd_fields", DW'({cmd_addr, cmd_length}), DW'(cmd_q.pop_front()));
      end
      if (done) done_seen++;
    end
  end

  task automatic applyStimulus(input logic [63:0] base, input logic [31:0] total);
    logic [31:0] rem, issued, b;
    @(posedge clk); #1;
    cmd_seen = 0; beats_seen = 0; done_seen = 0;
    for (int k = 0; k < int'(total); k++) begin
      data_q.push_back(mkData(k % EN, pred_cnt[k % EN]));
      pred_cnt[k % EN]++;
    end
    rem = total; issued = 0;
    while (rem > 0) begin
      b = (rem < 64) ? rem : 32'd64;
      cmd_q.push_back({base + 64'(issued) * 64'd64, b * 32'd64});
      issued += b;
      rem -= b;
    end
    start = 1'b1; addr_base = base; total_beats = total;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < budget);
    checkOutput("done_timeout", DW'(done), DW'(1));
    @(negedge clk);
  endtask

  task automatic waitBeat(input logic [31:0] target, input int budget);
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (beat_cnt != target && cyc < budget);
    checkOutput("beat_wait_timeout", DW'(beat_cnt), DW'(target));
  endtask

  task automatic finishPass(input int exp_cmds, input int exp_beats);
    checkOutput("cmd_count", DW'(cmd_seen), DW'(exp_cmds));
    checkOutput("beat_count", DW'(beats_seen), DW'(exp_beats));
    checkOutput("done_pulses", DW'(done_seen), DW'(1));
    checkOutput("beat_cnt", DW'(beat_cnt), DW'(exp_beats));
    checkOutput("data_q_left", DW'(data_q.size()), DW'(0));
    checkOutput("cmd_q_left", DW'(cmd_q.size()), DW'(0));
    checkOutput("busy_after", DW'(busy), DW'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; addr_base = '0; total_beats = '0;
    out_almost_full = 1'b0; empty_force = '0;
    for (int i = 0; i < EN; i++) pred_cnt[i] = 0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", DW'(busy), DW'(0));
    checkOutput("rst_done", DW'(done), DW'(0));
    checkOutput("rst_cmd", DW'({cmd_start, cmd_addr, cmd_length}), DW'(0));
    checkOutput("rst_out", DW'({out_valid, beat_cnt, src_rd_en, stall_cycles}), DW'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] pass of 128 beats");
    applyStimulus(64'h1000_0000, 32'd128);
    waitDone(1000);
    finishPass(2, 128);

    $display("[TB] pass of 72 beats");
    applyStimulus(64'h1000_0000, 32'd72);
    waitDone(1000);
    finishPass(2, 72);

    $display("[TB] zero-length pass");
    applyStimulus(64'h3000_0000, 32'd0);
    @(negedge clk);
    checkOutput("zero_done_high", DW'(done), DW'(1));
    @(negedge clk);
    checkOutput("zero_done_low", DW'(done), DW'(0));
    finishPass(0, 0);

    $display("[TB] backpressure at engine 5");
    applyStimulus(64'h2000_0000, 32'd64);
    waitBeat(32'd5, 200);
    out_almost_full = 1'b1;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      checkOutput("bp_rd_en", DW'(src_rd_en), DW'(0));
      checkOutput("bp_beat_cnt", DW'(beat_cnt), DW'(5));
    end
    out_almost_full = 1'b0;
    #1 checkOutput("bp_resume_engine", DW'(src_rd_en), DW'(8'b0010_0000));
    waitDone(1000);
    finishPass(1, 64);
`ifdef SGD_WB_STALL_CNT_EN
    checkOutput("bp_stall_cycles", DW'(stall_cycles), DW'(10));
`else
    checkOutput("bp_stall_cycles", DW'(stall_cycles), DW'(0));
`endif

    $display("[TB] engine 3 empty");
    applyStimulus(64'h2000_4000, 32'd32);
    waitBeat(32'd3, 200);
    empty_force = 8'b0000_1000;
    #1;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      checkOutput("empty_rd_en", DW'(src_rd_en), DW'(0));
      checkOutput("empty_beat_cnt", DW'(beat_cnt), DW'(3));
    end
    empty_force = '0;
    #1 checkOutput("empty_resume_engine", DW'(src_rd_en), DW'(8'b0000_1000));
    waitDone(1000);
    finishPass(1, 32);
`ifdef SGD_WB_STALL_CNT_EN
    checkOutput("empty_stall_cycles", DW'(stall_cycles), DW'(20));
`else
    checkOutput("empty_stall_cycles", DW'(stall_cycles), DW'(0));
`endif

    $display("[TB] reset during DATA");
    applyStimulus(64'h4000_0000, 32'd64);
    waitBeat(32'd10, 200);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy_done", DW'({busy, done}), DW'(0));
    checkOutput("mid_rst_cmd", DW'({cmd_start, cmd_addr, cmd_length}), DW'(0));
    checkOutput("mid_rst_out", DW'({out_valid, beat_cnt, src_rd_en, stall_cycles}), DW'(0));
    checkOutput("mid_rst_data", out_data, DW'(0));
    repeat (2) @(negedge clk);
    data_q.delete();
    cmd_q.delete();
    for (int i = 0; i < EN; i++) pred_cnt[i] = fifo_cnt[i];
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(64'h5000_0000, 32'd8);
    waitDone(200);
    finishPass(1, 8);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
